key_sel_ctrl: RTL and testbench
===============================

# key_sel_ctrl

User-input front end for the three-channel running-light top level. It takes three active-low push buttons, synchronises and debounces each one, and turns each button into a 2-bit pattern select for one running-light channel. A short press advances that channel's pattern (0→1→2→3→0). A long press sets that channel's pattern back to 0.

## Interface
Parameters:
- DEB_CYCLES, default 1_000_000: consecutive cycles a synchronised level must hold before it is accepted (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, default 50_000_000: cycles a debounced press must be held to count as a long press; must be greater than DEB_CYCLES.
- CNT_W, default 26: width of the debounce and hold counters; must satisfy 2^CNT_W > LONG_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_n  input  3  raw push buttons, active-low, asynchronous to clk; bit i drives channel i.
- sel_0  output  2  pattern select for channel 0.
- sel_1  output  2  pattern select for channel 1.
- sel_2  output  2  pattern select for channel 2.
- evt  output  3  one-cycle pulse; bit i is high in the cycle after any change of sel_i.

## Operation
- Three identical, independent channels; none of them shares state with another.
- Synchroniser: two flops per key, reset to 1 (released).
- Debounce:
  - stable_i resets to 1.
  - While sync_i ≠ stable_i, dcnt_i increments each cycle.
  - When a mismatch is seen with dcnt_i == DEB_CYCLES-1, stable_i takes sync_i and dcnt_i is cleared.
  - Any cycle with sync_i == stable_i clears dcnt_i, so a glitch restarts the count.
- Per-channel FSM: states IDLE, PRESSED, LONG; reset state IDLE.
  - IDLE: on stable_i = 0, go to PRESSED and clear hcnt_i.
  - PRESSED: hcnt_i increments each cycle.
    - If stable_i = 1 (release) first: sel_i ← sel_i + 1 mod 4, evt_i pulses, go to IDLE.
    - If hcnt_i == LONG_CYCLES-1 while still pressed: sel_i ← 0, evt_i pulses, go to LONG. The pulse occurs even if sel_i was already 0.
  - LONG: wait for stable_i = 1, then go to IDLE. The release does not change sel_i and does not pulse evt_i.
- Arithmetic: sel wraps from 3 to 0 with no carry. hcnt_i saturates in LONG, so it never wraps.
- Reset values: sel_0 = sel_1 = sel_2 = 0, evt = 0, all FSMs in IDLE, all counters 0, synchroniser and stable flops at 1.
- Reset mid-operation (asserted during a press, or during debounce): all state returns to reset values immediately. A key still held when reset is released is treated as a new press once it debounces.
- Simultaneous events:
  - Keys on different channels act independently, in the same cycle if they happen to coincide.
  - Within one channel, if release and long-press expiry coincide, the release wins: sel increments and the FSM goes to IDLE.

## Timing
- Latency is measured from the first rising edge that samples key_n[i] at its new level; the input is held steady from then on.
  - Edge 2: sync_i takes the new level.
  - Edge DEB_CYCLES+2: stable_i takes the new level.
  - Edge DEB_CYCLES+3: the FSM acts. sel_i changes on this edge, and evt_i is high for exactly the following cycle.
- Long press: sel_i clears LONG_CYCLES edges after PRESSED is entered.
- A bounce shorter than DEB_CYCLES cycles never reaches stable_i.
- evt is registered and is never high for two consecutive cycles on the same bit.

## Test plan
Benches run with DEB_CYCLES=4 and LONG_CYCLES=16.
1. Reset: assert rst asynchronously mid-cycle with the keys idle → sel_0..2 = 0 and evt = 0 immediately, before the next edge.
2. Short press on key 0: key_n[0] low for 10 cycles, then high.
   - sel_0 stays 0 until release, then becomes 1 exactly 7 edges after the release is first sampled; evt[0] pulses once.
   - Repeat three more times → sel_0 goes 2, 3, 0 (wrap).
3. Bounce rejection: key_n[1] toggles low/high every 2 cycles for 40 cycles, then returns high → sel_1 stays 0 and evt[1] stays 0 throughout.
4. Long press: set sel_2 = 2 with two short presses, then hold key_n[2] low for 40 cycles.
   - sel_2 becomes 0, evt[2] pulses once while the key is held.
   - On release, sel_2 stays 0 and there is no evt pulse.
5. Concurrent channels: press keys 0 and 1 in the same cycle and release them 3 cycles apart → sel_0 and sel_1 each increment by 1, with evt pulses 3 cycles apart.
6. Reset during a press: hold key_n[0] low for 12 cycles, pulse rst, keep the key held for 30 more cycles, then release.
   - sel_0 = 0 right after reset.
   - The held key then becomes a long press: sel_0 stays 0 and evt[0] pulses once, 16 edges after PRESSED is re-entered.

Source files
------------

// File: rtl/key_sel_if.sv
// Button/select bundle between the push-button front end and the
// running-light channels. The slave side is the key_sel_ctrl block.
interface key_sel_if;
    logic [2:0] key_n;
    logic [1:0] sel_0;
    logic [1:0] sel_1;
    logic [1:0] sel_2;
    logic [2:0] evt;

    modport master (
        output key_n,
        input  sel_0,
        input  sel_1,
        input  sel_2,
        input  evt
    );

    modport slave (
        input  key_n,
        output sel_0,
        output sel_1,
        output sel_2,
        output evt
    );
endinterface

// File: rtl/key_sel_ctrl.sv
// Three-channel push-button front end: each active-low key is synchronised,
// debounced and turned into a 2-bit pattern select. A short press advances
// the pattern, a long press forces it back to 0. Channels are independent.
module key_sel_ctrl #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    key_sel_if.slave   bus
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       stable;
    logic [CNT_W-1:0] dcnt [3];
    logic [CNT_W-1:0] hcnt [3];
    state_t           state [3];
    logic [1:0]       sel_r [3];
    logic [2:0]       evt_r;

    // Two-flop synchroniser; idles at 1 so reset looks like "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
        end else begin
            sync_a <= bus.key_n;
            sync_b <= sync_a;
        end
    end

    // Debounce: a new level is accepted only after DEB_CYCLES consecutive
    // mismatching cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 3'b111;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] != stable[i]) begin
                    if (dcnt[i] == DEB_MAX) begin
                        stable[i] <= sync_b[i];
                        dcnt[i]   <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Per-channel press FSM with registered select and one-cycle event.
    // Release is tested before long-press expiry so a coincident release wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_r <= '0;
            for (int i = 0; i < 3; i++) begin
                state[i] <= IDLE;
                hcnt[i]  <= '0;
                sel_r[i] <= 2'd0;
            end
        end else begin
            evt_r <= '0;
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    IDLE: begin
                        if (!stable[i]) begin
                            state[i] <= PRESSED;
                            hcnt[i]  <= '0;
                        end
                    end
                    PRESSED: begin
                        if (stable[i]) begin
                            sel_r[i] <= sel_r[i] + 2'd1;
                            evt_r[i] <= 1'b1;
                            state[i] <= IDLE;
                        end else if (hcnt[i] == LONG_MAX) begin
                            sel_r[i] <= 2'd0;
                            evt_r[i] <= 1'b1;
                            state[i] <= LONG;
                        end else begin
                            hcnt[i] <= hcnt[i] + 1'b1;
                        end
                    end
                    LONG: begin
                        // hcnt is held here so it cannot wrap on very long holds
                        if (stable[i]) state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign bus.sel_0 = sel_r[0];
    assign bus.sel_1 = sel_r[1];
    assign bus.sel_2 = sel_r[2];
    assign bus.evt   = evt_r;

endmodule

// File: tb/tb_key_sel_ctrl.sv
// Directed bench for key_sel_ctrl with DEB_CYCLES=4, LONG_CYCLES=16.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_key_sel_ctrl;

    localparam int DEB  = 4;
    localparam int LNG  = 16;
    localparam int ACT  = DEB + 3;   // edge on which the FSM acts after a key change

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;
    int evt_cnt [3] = '{0, 0, 0};
    int dbl_evt = 0;
    logic [2:0] evt_prev = 3'b000;

    key_sel_if bus ();

    key_sel_ctrl #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LNG),
        .CNT_W      (26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count event pulses per channel and any back-to-back pulse on one bit.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (bus.evt[i]) evt_cnt[i]++;
        if ((bus.evt & evt_prev) != 3'b000) dbl_evt++;
        evt_prev <= bus.evt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int get_sel(input int ch);
        case (ch)
            0:       return int'(bus.sel_0);
            1:       return int'(bus.sel_1);
            default: return int'(bus.sel_2);
        endcase
    endfunction

    // Short press with exact release-to-update timing checks.
    task automatic short_press(input int ch, input int hold, input int exp_sel);
        bus.key_n[ch] = 1'b0;
        repeat (hold) tick();
        bus.key_n[ch] = 1'b1;
        repeat (ACT - 1) tick();
        check($sformatf("sp%0d_hold", ch), get_sel(ch), (exp_sel + 3) % 4);
        check($sformatf("sp%0d_evt_early", ch), int'(bus.evt[ch]), 0);
        tick();
        check($sformatf("sp%0d_sel", ch), get_sel(ch), exp_sel);
        check($sformatf("sp%0d_evt", ch), int'(bus.evt[ch]), 1);
        tick();
        check($sformatf("sp%0d_evt_off", ch), int'(bus.evt[ch]), 0);
        repeat (3) tick();
    endtask

    initial begin
        int snap;
        int snap1;
        bus.key_n = 3'b111;

        // Power-on reset
        repeat (3) tick();
        check("rst_sel0", int'(bus.sel_0), 0);
        check("rst_sel1", int'(bus.sel_1), 0);
        check("rst_sel2", int'(bus.sel_2), 0);
        check("rst_evt",  int'(bus.evt), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Short presses on key 0, including the 3 -> 0 wrap
        short_press(0, 10, 1);
        short_press(0, 10, 2);
        short_press(0, 10, 3);
        short_press(0, 10, 0);
        check("sp0_evt_count", evt_cnt[0], 4);

        // Bounce on key 1 never reaches the debounced level
        snap = evt_cnt[1];
        for (int k = 0; k < 10; k++) begin
            bus.key_n[1] = 1'b0;
            repeat (2) tick();
            bus.key_n[1] = 1'b1;
            repeat (2) tick();
        end
        repeat (20) tick();
        check("bounce_sel1", int'(bus.sel_1), 0);
        check("bounce_evt1", evt_cnt[1] - snap, 0);

        // Long press on key 2 from sel_2 = 2
        short_press(2, 10, 1);
        short_press(2, 10, 2);
        snap = evt_cnt[2];
        bus.key_n[2] = 1'b0;
        repeat (ACT + LNG - 1) tick();
        check("long_sel2_before", int'(bus.sel_2), 2);
        tick();
        check("long_sel2_clear", int'(bus.sel_2), 0);
        check("long_evt2", int'(bus.evt[2]), 1);
        repeat (40 - ACT - LNG) tick();
        check("long_evt2_count", evt_cnt[2] - snap, 1);
        bus.key_n[2] = 1'b1;
        repeat (20) tick();
        check("long_rel_sel2", int'(bus.sel_2), 0);
        check("long_rel_evt2", evt_cnt[2] - snap, 1);

        // Concurrent keys 0 and 1, released 3 cycles apart
        snap  = evt_cnt[0];
        snap1 = evt_cnt[1];
        bus.key_n[1:0] = 2'b00;
        repeat (10) tick();
        bus.key_n[0] = 1'b1;
        repeat (3) tick();
        bus.key_n[1] = 1'b1;
        repeat (ACT - 3) tick();
        check("conc_sel0", int'(bus.sel_0), 1);
        check("conc_evt0", int'(bus.evt[0]), 1);
        check("conc_evt1_early", int'(bus.evt[1]), 0);
        repeat (2) tick();
        check("conc_sel1_early", int'(bus.sel_1), 0);
        tick();
        check("conc_sel1", int'(bus.sel_1), 1);
        check("conc_evt1", int'(bus.evt[1]), 1);
        repeat (5) tick();
        check("conc_evt0_count", evt_cnt[0] - snap, 1);
        check("conc_evt1_count", evt_cnt[1] - snap1, 1);

        // Asynchronous reset mid-cycle with keys idle
        short_press(2, 10, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sel0", int'(bus.sel_0), 0);
        check("arst_sel1", int'(bus.sel_1), 0);
        check("arst_sel2", int'(bus.sel_2), 0);
        check("arst_evt",  int'(bus.evt), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Reset during a press: held key becomes a fresh long press
        short_press(0, 10, 1);
        bus.key_n[0] = 1'b0;
        repeat (12) tick();
        #3;
        rst = 1'b1;
        #1;
        check("prst_sel0", int'(bus.sel_0), 0);
        tick();
        rst = 1'b0;
        snap = evt_cnt[0];
        repeat (ACT + LNG - 1) tick();
        check("prst_evt0_before", int'(bus.evt[0]), 0);
        tick();
        check("prst_evt0", int'(bus.evt[0]), 1);
        check("prst_sel0_long", int'(bus.sel_0), 0);
        repeat (30 - ACT - LNG) tick();
        bus.key_n[0] = 1'b1;
        repeat (20) tick();
        check("prst_sel0_rel", int'(bus.sel_0), 0);
        check("prst_evt0_count", evt_cnt[0] - snap, 1);

        check("evt_back_to_back", dbl_evt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
